// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared encodings and default latencies for the multiply/divide unit
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for a fixed latency; everything else is a move or a no-op.
  function automatic logic is_seq_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage request and HI/LO result bundle for the multiply/divide unit
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, rs, rt, input busy, hi, lo);
  modport slave  (input start, md_op, rs, rt, output busy, hi, lo);
endinterface

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational 64-bit {HI,LO} generator for mult/multu/div/divu
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        wr
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    b_safe = (b == 32'd0) ? 32'd1 : b;
    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b[31] ? (~b + 32'd1) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    q_s    = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;

    result = 64'd0;
    wr     = 1'b0;
    case (op)
      MD_MULT:  begin result = prod_s; wr = 1'b1; end
      MD_MULTU: begin result = prod_u; wr = 1'b1; end
      MD_DIV:   begin result = {r_s, q_s}; wr = (b != 32'd0); end
      MD_DIVU:  begin result = {a % b_safe, a / b_safe}; wr = (b != 32'd0); end
      default:  begin result = 64'd0; wr = 1'b0; end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide sequencer owning the HI/LO registers
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [63:0]      res, res_nxt;
  logic             res_wr, res_wr_nxt;
  logic [31:0]      hi, hi_nxt;
  logic [31:0]      lo, lo_nxt;
  logic [63:0]      calc_res;
  logic             calc_wr;
  logic             is_mult;

  md_calc u_calc (
    .op     (bus.md_op),
    .a      (bus.rs),
    .b      (bus.rt),
    .result (calc_res),
    .wr     (calc_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      res    <= '0;
      res_wr <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      res    <= res_nxt;
      res_wr <= res_wr_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    res_nxt    = res;
    res_wr_nxt = res_wr;
    hi_nxt     = hi;
    lo_nxt     = lo;
    is_mult    = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);
    case (state)
      ST_IDLE: begin
        if (bus.start && is_seq_op(bus.md_op)) begin
          res_nxt    = calc_res;
          res_wr_nxt = calc_wr;
          cnt_nxt    = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_nxt  = ST_RUN;
        end else if (!bus.start && bus.md_op == MD_MTHI) begin
          hi_nxt = bus.rs;
        end else if (!bus.start && bus.md_op == MD_MTLO) begin
          lo_nxt = bus.rs;
        end
      end
      ST_RUN: begin
        // Requests arriving here are dropped; the hazard unit keeps them from happening.
        if (cnt == CNT_W'(1)) begin
          if (res_wr) begin
            hi_nxt = res[63:32];
            lo_nxt = res[31:0];
          end
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule
